mux_scan_ctrl: RTL and testbench

Sequential scan controller that sits directly upstream of the 16:1 bit-select multiplexer and consumes its output. On a start request it latches a 16-bit word onto the mux data inputs and steps the mux select through all 16 positions, one position per accepted handshake beat. It streams each selected bit out over a valid/ready serial interface and reports the count of 1s streamed. Together with the mux it forms a parallel-to-serial converter with backpressure.

---
 rtl/mux_scan_ctrl.sv | 121 ++++++++++++
 tb/tb_mux_scan_ctrl.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl
// Scan controller for an external 16:1 bit-select mux. A start request in
// idle latches a 16-bit word onto the mux data inputs, then the mux select is
// stepped through all 16 positions, one position per accepted serial beat.
// The selected bit is streamed out over a valid/ready interface. The count of
// 1s streamed is reported on ones.
//
// Parameters:
//   LSB_FIRST  1: sel counts 0->15, 0: sel counts 15->0
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset, highest priority
//   start      scan request, honoured only in idle
//   word       data word captured on an accepted start
//   mux_in     holding register feeding the mux data inputs
//   sel        registered mux select
//   mux_out    mux output (combinational function of mux_in/sel)
//   ser_data   serial bit, straight pass-through of mux_out
//   ser_valid  ser_data valid (shift state)
//   ser_ready  downstream accepts the beat
//   busy       high in shift and done states
//   done       one-cycle pulse at the end of a scan
//   ones       number of 1 bits streamed in the current/last scan
module mux_scan_ctrl #(
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] word,
  output logic [15:0] mux_in,
  output logic [3:0]  sel,
  input  logic        mux_out,
  output logic        ser_data,
  output logic        ser_valid,
  input  logic        ser_ready,
  output logic        busy,
  output logic        done,
  output logic [4:0]  ones
);

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] mux_in_q, mux_in_d;
  logic [3:0]  sel_q, sel_d;
  logic [3:0]  beat_q, beat_d;
  logic [4:0]  ones_q, ones_d;

  always_comb begin
    state_d   = state_q;
    mux_in_d  = mux_in_q;
    sel_d     = sel_q;
    beat_d    = beat_q;
    ones_d    = ones_q;
    ser_valid = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          mux_in_d = word;
          sel_d    = LSB_FIRST ? 4'd0 : 4'd15;
          beat_d   = 4'd0;
          ones_d   = 5'd0;
          state_d  = StShift;
        end
      end
      StShift: begin
        ser_valid = 1'b1;
        busy      = 1'b1;
        if (ser_ready) begin
          // 16 beats at most, so the 5-bit count cannot wrap
          ones_d = ones_q + {4'd0, mux_out};
          if (beat_q == 4'd15) begin
            // sel parks on the last position until the next start
            state_d = StDone;
          end else begin
            beat_d = beat_q + 4'd1;
            sel_d  = LSB_FIRST ? sel_q + 4'd1 : sel_q - 4'd1;
          end
        end
      end
      StDone: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      mux_in_q <= 16'd0;
      sel_q    <= 4'd0;
      beat_q   <= 4'd0;
      ones_q   <= 5'd0;
    end else begin
      state_q  <= state_d;
      mux_in_q <= mux_in_d;
      sel_q    <= sel_d;
      beat_q   <= beat_d;
      ones_q   <= ones_d;
    end
  end

  assign mux_in   = mux_in_q;
  assign sel      = sel_q;
  assign ones     = ones_q;
  assign ser_data = mux_out;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Bench for mux_scan_ctrl. Two instances share all inputs: dut0 scans LSB
// first, dut1 scans MSB first. Each instance gets its own behavioural 16:1 mux.
module tb_mux_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst, start, ser_ready;
  logic [15:0] word;

  logic [15:0] mux_in0, mux_in1;
  logic [3:0]  sel0, sel1;
  logic        mux_out0, mux_out1, ser_data0, ser_data1;
  logic        ser_valid0, ser_valid1, busy0, busy1, done0, done1;
  logic [4:0]  ones0, ones1;
  logic [28:0] obs [2];

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  assign mux_out0 = mux_in0[sel0];
  assign mux_out1 = mux_in1[sel1];
  assign obs[0] = {mux_in0, sel0, ser_data0, ser_valid0, busy0, done0, ones0};
  assign obs[1] = {mux_in1, sel1, ser_data1, ser_valid1, busy1, done1, ones1};

  mux_scan_ctrl #(.LSB_FIRST(1'b1)) dut0 (
    .clk(clk), .rst(rst), .start(start), .word(word), .mux_in(mux_in0), .sel(sel0),
    .mux_out(mux_out0), .ser_data(ser_data0), .ser_valid(ser_valid0),
    .ser_ready(ser_ready), .busy(busy0), .done(done0), .ones(ones0)
  );

  mux_scan_ctrl #(.LSB_FIRST(1'b0)) dut1 (
    .clk(clk), .rst(rst), .start(start), .word(word), .mux_in(mux_in1), .sel(sel1),
    .mux_out(mux_out1), .ser_data(ser_data1), .ser_valid(ser_valid1),
    .ser_ready(ser_ready), .busy(busy1), .done(done1), .ones(ones1)
  );

  // Reference model: phase 0 idle, 1 streaming, 2 done cycle.
  int          m_phase;
  logic [15:0] m_word;
  logic [3:0]  m_sel [2];
  int          m_cnt;
  logic [4:0]  m_ones [2];

  function automatic logic [28:0] exp_vec(input int d);
    return {m_word, m_sel[d], m_word[m_sel[d]], m_phase == 1, m_phase != 0, m_phase == 2,
            m_ones[d]};
  endfunction

  // Advance one clock: model follows the inputs present at the edge.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      m_phase = 0; m_word = 16'd0; m_cnt = 0;
      m_sel[0] = 4'd0; m_sel[1] = 4'd0; m_ones[0] = 5'd0; m_ones[1] = 5'd0;
    end else if (m_phase == 0) begin
      if (start) begin
        m_phase = 1; m_word = word; m_cnt = 0;
        m_sel[0] = 4'd0; m_sel[1] = 4'd15; m_ones[0] = 5'd0; m_ones[1] = 5'd0;
      end
    end else if (m_phase == 1) begin
      if (ser_ready) begin
        for (int d = 0; d < 2; d++) m_ones[d] = m_ones[d] + 5'(m_word[m_sel[d]]);
        if (m_cnt == 15) m_phase = 2;
        else begin
          m_cnt++;
          m_sel[0] = m_sel[0] + 4'd1;
          m_sel[1] = m_sel[1] - 4'd1;
        end
      end
    end else begin
      m_phase = 0;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    // Start a scan, get part way, then reset for two cycles.
    start = 1'b1; word = 16'h5A5A; ser_ready = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    rst = 1'b1;
    tick();
    start = 1'b1;  // rst must win over start
    tick();
    rst = 1'b0; start = 1'b0;
    for (int d = 0; d < 2; d++) begin
      tests++;
      if (obs[d] !== 29'd0) begin
        failed++;
        $display("FAIL reset_state dut%0d: got %h expected %h", d, obs[d], 29'd0);
      end
      tests++;
      if (obs[d] !== exp_vec(d)) begin
        failed++;
        $display("FAIL reset_model dut%0d: got %h expected %h", d, obs[d], exp_vec(d));
      end
    end
    tick();
  endtask

  // One full scan with an optional stall at a given LSB-first position and optional
  // start pokes while busy. Checks every cycle against the model plus end results.
  task automatic test_scan(input string name, input logic [15:0] w, input int stall_sel,
                           input int stall_len, input bit poke, input logic [4:0] exp_ones,
                           input int exp_lat);
    int c = 1;
    int stalled = 0;
    int nb = 0;
    int done_c = -1;
    logic [15:0] bits0 = 16'd0;
    logic [15:0] bits1 = 16'd0;
    start = 1'b1; word = w; ser_ready = 1'b1;
    tick();
    start = 1'b0;
    while (c < 80 && done_c < 0) begin
      for (int d = 0; d < 2; d++) begin
        tests++;
        if (obs[d] !== exp_vec(d)) begin
          failed++;
          $display("FAIL %s cycle %0d dut%0d: got %h expected %h", name, c, d, obs[d],
                   exp_vec(d));
        end
      end
      ser_ready = 1'b1;
      if (m_phase == 1 && int'(m_sel[0]) == stall_sel && stalled < stall_len) begin
        ser_ready = 1'b0;
        stalled++;
      end
      start = poke && (m_phase == 2 || $urandom_range(0, 1) == 1);
      word  = ~w ^ 16'(($urandom_range(0, 65535)));
      if (done0) done_c = c;
      if (m_phase == 1 && ser_ready) begin
        bits0[nb] = ser_data0;
        bits1[15 - nb] = ser_data1;
        nb++;
      end
      tick();
      c++;
    end
    start = 1'b0;
    tests++;
    if (done_c != exp_lat) begin
      failed++;
      $display("FAIL %s_latency: got %0d expected %0d", name, done_c, exp_lat);
    end
    tests++;
    if (bits0 !== w || bits1 !== w) begin
      failed++;
      $display("FAIL %s_stream: got %h/%h expected %h", name, bits0, bits1, w);
    end
    tests++;
    if (ones0 !== exp_ones || ones1 !== exp_ones) begin
      failed++;
      $display("FAIL %s_ones: got %0d/%0d expected %0d", name, ones0, ones1, exp_ones);
    end
    tests++;
    if (mux_in0 !== w || mux_in1 !== w) begin
      failed++;
      $display("FAIL %s_mux_in: got %h/%h expected %h", name, mux_in0, mux_in1, w);
    end
  endtask

  task automatic test_back_to_back();
    int c = 1;
    int ndone = 0;
    int first = -1;
    int second = -1;
    start = 1'b1; word = 16'hFFFF; ser_ready = 1'b1;
    tick();
    while (c <= 36) begin
      for (int d = 0; d < 2; d++) begin
        tests++;
        if (obs[d] !== exp_vec(d)) begin
          failed++;
          $display("FAIL b2b cycle %0d dut%0d: got %h expected %h", c, d, obs[d], exp_vec(d));
        end
      end
      if (done0) begin
        ndone++;
        if (first < 0) first = c; else second = c;
        tests++;
        if (ones0 !== 5'b10000 || ones1 !== 5'b10000) begin
          failed++;
          $display("FAIL b2b_ones cycle %0d: got %0d/%0d expected 16", c, ones0, ones1);
        end
      end
      if (c == 36) start = 1'b0;
      tick();
      c++;
    end
    tests++;
    if (ndone != 2 || first != 17 || second != 35) begin
      failed++;
      $display("FAIL b2b_done: got %0d pulses at %0d,%0d expected 2 at 17,35", ndone, first,
               second);
    end
  endtask

  task automatic test_random();
    for (int s = 0; s < 6; s++) begin
      logic [15:0] w = 16'($urandom_range(0, 65535));
      int c = 0;
      start = 1'b1; word = w;
      tick();
      start = 1'b0;
      while (c < 200 && !done0) begin
        for (int d = 0; d < 2; d++) begin
          tests++;
          if (obs[d] !== exp_vec(d)) begin
            failed++;
            $display("FAIL random scan %0d cycle %0d dut%0d: got %h expected %h", s, c, d,
                     obs[d], exp_vec(d));
          end
        end
        ser_ready = ($urandom_range(0, 9) < 7);
        start = ($urandom_range(0, 3) == 0);
        word = 16'($urandom_range(0, 65535));
        tick();
        c++;
      end
      start = 1'b0;
      tests++;
      if (!done0 || ones0 !== 5'($countones(w)) || ones1 !== 5'($countones(w))) begin
        failed++;
        $display("FAIL random_ones scan %0d: done %b got %0d/%0d expected %0d", s, done0,
                 ones0, ones1, $countones(w));
      end
      tick();
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; word = 16'd0; ser_ready = 1'b0;
    @(negedge clk);
    tick();
    tick();
    rst = 1'b0;
    tick();
    test_reset();
    test_scan("lsb_a5c3", 16'hA5C3, -1, 0, 1'b0, 5'd8, 17);
    tick();
    test_scan("backpressure", 16'hA5C3, 5, 3, 1'b0, 5'd8, 20);
    tick();
    test_scan("start_ignored", 16'hA5C3, 9, 2, 1'b1, 5'd8, 19);
    tick();
    test_scan("msb_8001", 16'h8001, -1, 0, 1'b0, 5'd2, 17);
    tick();
    test_back_to_back();
    tick();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
